// File: rtl/probe_conditioner_pkg.sv
// Shared constants for the probe conditioner: channel modes, default sizing,
// and the mode-dependent output selection used by each channel.
package probeConditioner_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LEVEL = 2'd0;
  localparam mode_t MODE_RISE  = 2'd1;
  localparam mode_t MODE_FALL  = 2'd2;
  localparam mode_t MODE_ANY   = 2'd3;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_FILTER_W    = 4;

  // Edges come only from the filtered level history, so a mode switch alone
  // can never manufacture a pulse.
  function automatic logic mode_output(input mode_t mode, input logic f, input logic fp);
    logic rise;
    logic fall;
    rise = f & ~fp;
    fall = ~f & fp;
    case (mode)
      MODE_LEVEL: return f;
      MODE_RISE:  return rise;
      MODE_FALL:  return fall;
      default:    return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/probe_conditioner_channel.sv
// One probe channel: free-running synchronizer, clock-gated glitch filter,
// edge detector and registered mode-selected output.
module probe_conditioner_channel
  import probeConditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_W    = DEFAULT_FILTER_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  input  logic                i_raw,
  input  mode_t               i_mode,
  input  logic [FILTER_W-1:0] i_filterLen,
  output logic                o_sample,
  output logic                o_level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  logic [FILTER_W-1:0] cnt_q;
  logic [FILTER_W-1:0] cnt_d;
  logic                f_q;
  logic                f_d;
  logic                fp_q;
  logic                fp_d;
  logic                out_q;
  logic                out_d;

  assign sync_d[0] = i_raw;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end
  assign s = sync_q[SYNC_STAGES-1];

  // The >= also covers a length shrunk below an in-flight count.
  always_comb begin
    cnt_d = cnt_q;
    f_d   = f_q;
    fp_d  = fp_q;
    out_d = out_q;
    if (i_cg) begin
      fp_d  = f_q;
      out_d = mode_output(i_mode, f_q, fp_q);
      if (s == f_q) begin
        cnt_d = '0;
      end else if (cnt_q >= i_filterLen) begin
        f_d   = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
      fp_q   <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      fp_q   <= fp_d;
      out_q  <= out_d;
    end
  end

  assign o_sample = out_q;
  assign o_level  = f_q;

endmodule

// File: rtl/probe_conditioner.sv
// Two independent probe channels (x, y) sharing the clock gate and the
// glitch-filter length, feeding the correlator's x/y sample inputs.
module probe_conditioner
  import probeConditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_W    = DEFAULT_FILTER_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  input  logic                i_xRaw,
  input  logic                i_yRaw,
  input  logic [1:0]          i_xMode,
  input  logic [1:0]          i_yMode,
  input  logic [FILTER_W-1:0] i_filterLen,
  output logic                o_x,
  output logic                o_y,
  output logic                o_xLevel,
  output logic                o_yLevel
);

  logic [1:0] raw_w;
  logic [1:0] sample_w;
  logic [1:0] level_w;
  mode_t      mode_w [2];

  assign raw_w     = {i_yRaw, i_xRaw};
  assign mode_w[0] = i_xMode;
  assign mode_w[1] = i_yMode;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    probe_conditioner_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_W   (FILTER_W)
    ) u_channel (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_cg       (i_cg),
      .i_raw      (raw_w[gi]),
      .i_mode     (mode_w[gi]),
      .i_filterLen(i_filterLen),
      .o_sample   (sample_w[gi]),
      .o_level    (level_w[gi])
    );
  end

  assign o_x      = sample_w[0];
  assign o_y      = sample_w[1];
  assign o_xLevel = level_w[0];
  assign o_yLevel = level_w[1];

endmodule

// File: tb/tb_probe_conditioner.sv
// Directed timing checks plus randomized traffic compared against a
// streak-based behavioural model of the conditioner.
module tb_probe_conditioner;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cg;
  logic       x_raw, y_raw;
  logic [1:0] x_mode, y_mode;
  logic [3:0] flen;
  logic       o_x, o_y, o_xLevel, o_yLevel;

  int n_checks = 0;
  int n_pass   = 0;

  probe_conditioner dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cg       (cg),
    .i_xRaw     (x_raw),
    .i_yRaw     (y_raw),
    .i_xMode    (x_mode),
    .i_yMode    (y_mode),
    .i_filterLen(flen),
    .o_x        (o_x),
    .o_y        (o_y),
    .o_xLevel   (o_xLevel),
    .o_yLevel   (o_yLevel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: the pin is seen SS edges late; the filtered level flips
  // once the seen value has disagreed with it for more than L enabled edges.
  bit m_pipe [2][SS];
  bit m_f [2];
  bit m_fp [2];
  bit m_out [2];
  int m_streak [2];
  bit m_s, m_rose, m_fell, m_raw;
  int m_mode;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      m_raw  = (c == 0) ? x_raw : y_raw;
      m_mode = (c == 0) ? int'(x_mode) : int'(y_mode);
      if (rst) begin
        for (int k = 0; k < SS; k++) m_pipe[c][k] = 1'b0;
        m_f[c] = 0; m_fp[c] = 0; m_out[c] = 0; m_streak[c] = 0;
      end else begin
        m_s = m_pipe[c][SS-1];
        if (cg) begin
          m_rose = m_f[c] && !m_fp[c];
          m_fell = !m_f[c] && m_fp[c];
          case (m_mode)
            0: m_out[c] = m_f[c];
            1: m_out[c] = m_rose;
            2: m_out[c] = m_fell;
            default: m_out[c] = m_rose || m_fell;
          endcase
          m_fp[c] = m_f[c];
          if (m_s != m_f[c]) begin
            m_streak[c]++;
            if (m_streak[c] > int'(flen)) begin
              m_f[c] = m_s;
              m_streak[c] = 0;
            end
          end else begin
            m_streak[c] = 0;
          end
        end
        for (int k = SS - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
        m_pipe[c][0] = m_raw;
      end
    end
  end

  int saw_high;

  initial begin
    rst = 1; cg = 1; x_raw = 0; y_raw = 0; x_mode = 0; y_mode = 0; flen = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_o_x", o_x, 1'b0);
    check_eq("rst_o_y", o_y, 1'b0);
    check_eq("rst_xlvl", o_xLevel, 1'b0);
    check_eq("rst_ylvl", o_yLevel, 1'b0);
    rst = 0;
    repeat (3) @(negedge clk);

    // L=0 LEVEL latency: level after edge 2, output after edge 3
    x_raw = 1;
    @(negedge clk); check_eq("l0_lvl_e0", o_xLevel, 1'b0);
    @(negedge clk); check_eq("l0_lvl_e1", o_xLevel, 1'b0);
    @(negedge clk); check_eq("l0_lvl_e2", o_xLevel, 1'b1);
    check_eq("l0_ox_e2", o_x, 1'b0);
    @(negedge clk); check_eq("l0_ox_e3", o_x, 1'b1);

    // L=3: 3-cycle pulse rejected, 5-cycle pulse accepted then released
    x_raw = 0; flen = 3;
    repeat (12) @(negedge clk);
    check_eq("l3_settle", o_xLevel, 1'b0);
    x_raw = 1;
    saw_high = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) x_raw = 0;
      if (o_xLevel) saw_high = 1;
    end
    check_eq("l3_glitch_rejected", saw_high[0], 1'b0);
    x_raw = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 4) x_raw = 0;
      if (o_xLevel) saw_high = 1;
    end
    check_eq("l3_pulse_seen", saw_high[0], 1'b1);
    check_eq("l3_pulse_released", o_xLevel, 1'b0);

    // raw high through reset in RISE mode gives one pulse at edge SS+L+1
    rst = 1; x_raw = 1; x_mode = 2'd1; flen = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("rr_ox_in_rst", o_x, 1'b0);
      check_eq("rr_xlvl_in_rst", o_xLevel, 1'b0);
    end
    rst = 0;
    for (int k = 0; k <= SS + 2 + 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("rr_pulse_e%0d", k), o_x, (k == SS + 2 + 1));
    end

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      check_eq("rnd_o_x", o_x, m_out[0]);
      check_eq("rnd_o_y", o_y, m_out[1]);
      check_eq("rnd_xlvl", o_xLevel, m_f[0]);
      check_eq("rnd_ylvl", o_yLevel, m_f[1]);
      if ($urandom_range(0, 7) == 0) x_raw = ~x_raw;
      if ($urandom_range(0, 7) == 0) y_raw = ~y_raw;
      cg = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) x_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) y_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) flen = 4'($urandom_range(0, 5));
      rst = ($urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
